// File: rtl/adc_frame_rx.sv
// SPI frame reader for a dual-channel ADC: pulses ad_conv, clocks one frame in on spi_miso, presents two samples.
// Optional: define ADC_OVR_EN to add the ovr full-scale clip flag.
module adc_frame_rx #(
    parameter int CLK_DIV   = 2,
    parameter int DATA_W    = 14,
    parameter int FRAME_LEN = 34
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] ch0,
    output logic [DATA_W-1:0] ch1,
    output logic              ad_conv,
    output logic              spi_sck,
    input  logic              spi_miso
`ifdef ADC_OVR_EN
    ,
    output logic              ovr
`endif
);

    localparam int                DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]        BIT_LAST = 6'(FRAME_LEN - 1);
    // The first two frame bits are never needed, so they are allowed to fall off the end.
    localparam int                SR_W     = FRAME_LEN - 2;
    localparam int                CH0_MSB  = SR_W - 1;
    localparam int                CH1_MSB  = CH0_MSB - DATA_W - 2;

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [5:0]        bit_q, bit_d;
    logic              sck_q, sck_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [DATA_W-1:0] ch0_q, ch0_d, ch1_q, ch1_d;
    logic              div_wrap;
`ifdef ADC_OVR_EN
    localparam logic [DATA_W-1:0] FS_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] FS_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    logic ovr_q, ovr_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            sr_q    <= '0;
            ch0_q   <= '0;
            ch1_q   <= '0;
`ifdef ADC_OVR_EN
            ovr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            sr_q    <= sr_d;
            ch0_q   <= ch0_d;
            ch1_q   <= ch1_d;
`ifdef ADC_OVR_EN
            ovr_q   <= ovr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sck_d    = sck_q;
        sr_d     = sr_q;
        ch0_d    = ch0_q;
        ch1_d    = ch1_q;
`ifdef ADC_OVR_EN
        ovr_d    = ovr_q;
`endif
        div_wrap = (div_q == DIV_LAST);
        case (state_q)
            IDLE: begin
                div_d = '0;
                bit_d = '0;
                sck_d = 1'b0;
                if (start) state_d = CONV;
            end
            CONV: begin
                // bit_q[0] marks the second half-period of the conversion pulse.
                div_d = div_wrap ? '0 : div_q + DIV_W'(1);
                if (div_wrap) begin
                    if (bit_q[0]) begin
                        state_d = SHIFT;
                        bit_d   = '0;
                    end else begin
                        bit_d   = 6'd1;
                    end
                end
            end
            SHIFT: begin
                div_d = div_wrap ? '0 : div_q + DIV_W'(1);
                if (div_wrap) begin
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        sr_d = {sr_q[SR_W-2:0], spi_miso};
                    end else if (bit_q == BIT_LAST) begin
                        state_d = DONE;
                        ch0_d   = sr_q[CH0_MSB -: DATA_W];
                        ch1_d   = sr_q[CH1_MSB -: DATA_W];
`ifdef ADC_OVR_EN
                        ovr_d   = (sr_q[CH0_MSB -: DATA_W] == FS_POS) ||
                                  (sr_q[CH0_MSB -: DATA_W] == FS_NEG) ||
                                  (sr_q[CH1_MSB -: DATA_W] == FS_POS) ||
                                  (sr_q[CH1_MSB -: DATA_W] == FS_NEG);
`endif
                    end else begin
                        bit_d = bit_q + 6'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                div_d   = '0;
                bit_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q == CONV) || (state_q == SHIFT);
    assign valid   = (state_q == DONE);
    assign ad_conv = (state_q == CONV);
    assign spi_sck = sck_q;
    assign ch0     = ch0_q;
    assign ch1     = ch1_q;
`ifdef ADC_OVR_EN
    assign ovr     = ovr_q;
`endif

endmodule

// File: tb/tb_adc_frame_rx.sv
// Bench for adc_frame_rx: two instances (CLK_DIV=2 and 1) fed by an ADC serial model, scoreboard-checked.
module tb_adc_frame_rx;
    localparam int CD0 = 2;
    localparam int CD1 = 1;

    typedef struct {
        logic [13:0] c0;
        logic [13:0] c1;
        int          cyc;
        logic        ovr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start   [2] = '{default: 1'b0};
    logic        busy    [2];
    logic        valid   [2];
    logic        ad_conv [2];
    logic        spi_sck [2];
    logic        miso    [2] = '{default: 1'b1};
    logic        ovr     [2];
    logic [13:0] ch0     [2];
    logic [13:0] ch1     [2];

    logic [33:0] frm [2] = '{default: '0};
    int          idx [2] = '{default: 0};
    logic        sck_p [2] = '{default: 1'b0};
    logic        conv_p [2] = '{default: 1'b0};
    int          conv_len [2] = '{default: 0};
    int          last_rise [2] = '{default: -1};
    int          nrise [2] = '{default: 0};
    int          nval [2] = '{default: 0};
    int          rises [2] = '{default: 0};
    int          last_v [2] = '{default: -1};
    bit          held [2] = '{default: 1'b0};
    exp_t        q0 [$];
    exp_t        q1 [$];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_frame_rx #(.CLK_DIV(CD0)) u0 (
        .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .valid(valid[0]),
        .ch0(ch0[0]), .ch1(ch1[0]), .ad_conv(ad_conv[0]), .spi_sck(spi_sck[0]),
        .spi_miso(miso[0])
`ifdef ADC_OVR_EN
        , .ovr(ovr[0])
`endif
    );

    adc_frame_rx #(.CLK_DIV(CD1)) u1 (
        .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .valid(valid[1]),
        .ch0(ch0[1]), .ch1(ch1[1]), .ad_conv(ad_conv[1]), .spi_sck(spi_sck[1]),
        .spi_miso(miso[1])
`ifdef ADC_OVR_EN
        , .ovr(ovr[1])
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic clip(input logic [13:0] v);
        return (v == 14'h1FFF) || (v == 14'h2000);
    endfunction

    function automatic int cdiv(input int d);
        return (d == 0) ? CD0 : CD1;
    endfunction

    task automatic push_exp(input int d, input logic [13:0] c0, input logic [13:0] c1, input int at);
        exp_t e;
        e.c0 = c0; e.c1 = c1; e.cyc = at; e.ovr = clip(c0) || clip(c1);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Called on a negedge with the DUT idle; returns on the negedge of the first CONV cycle.
    task automatic frame(input int d, input logic [13:0] c0, input logic [13:0] c1);
        chk("busy_before_start", busy[d], 0);
        frm[d] = {2'b11, c0, 2'b11, c1, 2'b11};
        start[d] = 1'b1;
        push_exp(d, c0, c1, cyc + 1 + 70 * cdiv(d));
        @(negedge clk);
        start[d] = 1'b0;
        chk("busy_after_start", busy[d], 1);
    endtask

    task automatic drain(input int d);
        repeat (70 * cdiv(d) + 10) @(negedge clk);
        chk("drain", (d == 0) ? q0.size() : q1.size(), 0);
    endtask

    // ADC model drives the next bit after each sck fall; the monitor checks timing and scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ad_conv[d]) idx[d] = 0;
            else if (sck_p[d] && !spi_sck[d]) idx[d] = idx[d] + 1;
            miso[d] = (idx[d] < 34) ? frm[d][33 - idx[d]] : 1'b1;

            if (ad_conv[d] && !conv_p[d]) begin
                rises[d]++;
                conv_len[d] = 0;
                last_rise[d] = -1;
                nrise[d] = 0;
                if (held[d] && last_v[d] >= 0) chk("conv_after_valid", cyc - last_v[d], 2);
            end
            if (ad_conv[d]) conv_len[d]++;
            if (!ad_conv[d] && conv_p[d]) chk("conv_width", conv_len[d], 2 * cdiv(d));
            if (spi_sck[d] && !sck_p[d]) begin
                if (last_rise[d] >= 0) chk("sck_period", cyc - last_rise[d], 2 * cdiv(d));
                last_rise[d] = cyc;
                nrise[d]++;
            end
            if (valid[d]) begin
                exp_t e;
                bit   have = 1'b0;
                nval[d]++;
                last_v[d] = cyc;
                chk("busy_at_valid", busy[d], 0);
                chk("sck_per_frame", nrise[d], 34);
                if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                if (!have) chk("unexpected_valid", 1, 0);
                else begin
                    chk("ch0", ch0[d], e.c0);
                    chk("ch1", ch1[d], e.c1);
                    chk("valid_cycle", cyc, e.cyc);
`ifdef ADC_OVR_EN
                    chk("ovr", ovr[d], e.ovr);
`endif
                end
            end
            sck_p[d] = spi_sck[d];
            conv_p[d] = ad_conv[d];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, v, t;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy[0], 0);
        chk("rst_valid", valid[0], 0);
        chk("rst_conv", ad_conv[0], 0);
        chk("rst_sck", spi_sck[0], 0);
        chk("rst_ch0", ch0[0], 0);
        chk("rst_ch1", ch1[0], 0);
`ifdef ADC_OVR_EN
        chk("rst_ovr", ovr[0], 0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // basic frame
        frame(0, 14'h1ABC, 14'h2345);
        drain(0);

        // start during sck period 10 is ignored
        r = rises[0]; v = nval[0];
        frame(0, 14'h0123, 14'h3E01);
        repeat (4 + 40) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        drain(0);
        chk("one_valid", nval[0] - v, 1);
        chk("one_conv", rises[0] - r, 1);

        // reset in sck period 20 aborts
        frame(0, 14'h0555, 14'h2AAA);
        repeat (4 + 80 + 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_conv", ad_conv[0], 0);
        chk("abort_sck", spi_sck[0], 0);
        chk("abort_busy", busy[0], 0);
        chk("abort_valid", valid[0], 0);
        chk("abort_ch0", ch0[0], 0);
        chk("abort_ch1", ch1[0], 0);
        reset = 1'b0;
        q0.delete();
        v = nval[0];
        repeat (150) @(negedge clk);
        chk("no_valid_after_abort", nval[0] - v, 0);
        frame(0, 14'h0F0F, 14'h30C3);
        drain(0);

        // start held for three back-to-back frames
        v = nval[0];
        held[0] = 1'b1;
        last_v[0] = -1;
        frm[0] = {2'b11, 14'h1234, 2'b11, 14'h0777, 2'b11};
        t = cyc;
        start[0] = 1'b1;
        push_exp(0, 14'h1234, 14'h0777, t + 141);
        push_exp(0, 14'h1234, 14'h0777, t + 141 + 142);
        push_exp(0, 14'h1234, 14'h0777, t + 141 + 284);
        repeat (425) @(negedge clk);
        start[0] = 1'b0;
        drain(0);
        held[0] = 1'b0;
        chk("held_valids", nval[0] - v, 3);

        // CLK_DIV=1 instance, extreme codes
        frame(1, 14'h0000, 14'h3FFF);
        drain(1);

        // full-scale clip then in-range frame
        frame(0, 14'h1FFF, 14'h0001);
        drain(0);
        frame(0, 14'h0100, 14'h0001);
        drain(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
